// File: rtl/y86_alu_reg.sv
// rtl/y86_alu_reg.sv - Y86-64 execute-stage ALU (add/sub/and/xor) with registered result and flags
module y86_alu_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             c0,
    input  logic             c1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] output_alu,
    output logic             bit_overflow,
    output logic             zero_out,
    output logic             sign_out
);

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [WIDTH-1:0] result;
    logic             result_ovf;

    // Subtract reuses the adder: a + ~b + 1, carry-in supplied by is_sub.
    assign is_sub = c0 & ~c1;
    assign b_eff  = is_sub ? ~b : b;
    assign sum    = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

    // With b_eff inverted for subtract, "operands share a sign" becomes a[MSB] != b[MSB].
    assign add_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);

    always_comb begin
        result     = sum;
        result_ovf = 1'b0;
        unique case ({c1, c0})
            2'b00,
            2'b01: begin
                result     = sum;
                result_ovf = add_ovf;
            end
            2'b10:   result = a & b;
            default: result = a ^ b;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            output_alu   <= '0;
            bit_overflow <= 1'b0;
            zero_out     <= 1'b1;
            sign_out     <= 1'b0;
        end else begin
            output_alu   <= result;
            bit_overflow <= result_ovf;
            zero_out     <= (result == '0);
            sign_out     <= result[MSB];
        end
    end

endmodule

// File: tb/tb_y86_alu_reg.sv
// tb/tb_y86_alu_reg.sv - directed self-checking bench for y86_alu_reg
module tb_y86_alu_reg;

    logic        clock;
    logic        reset_n;
    logic        c0;
    logic        c1;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] output_alu;
    logic        bit_overflow;
    logic        zero_out;
    logic        sign_out;

    int n_checks = 0;
    int n_passed = 0;

    y86_alu_reg #(.WIDTH(64)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .c0           (c0),
        .c1           (c1),
        .a            (a),
        .b            (b),
        .output_alu   (output_alu),
        .bit_overflow (bit_overflow),
        .zero_out     (zero_out),
        .sign_out     (sign_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [63:0] e_alu, input logic e_ovf,
                        input logic e_zero, input logic e_sign);
        check({tag, ".alu"},  output_alu, e_alu);
        check({tag, ".ovf"},  {63'd0, bit_overflow}, {63'd0, e_ovf});
        check({tag, ".zero"}, {63'd0, zero_out},     {63'd0, e_zero});
        check({tag, ".sign"}, {63'd0, sign_out},     {63'd0, e_sign});
    endtask

    // Present inputs, then sample just after the next rising edge.
    task automatic op(input logic [1:0] fn, input logic [63:0] va, input logic [63:0] vb);
        {c1, c0} = fn;
        a = va;
        b = vb;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        {c1, c0} = 2'b00;
        a = 64'd0;
        b = 64'd0;

        // Reset held two cycles with an add pending
        op(2'b00, 64'd5, 64'd7);
        op(2'b00, 64'd5, 64'd7);
        chk4("reset", 64'd0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        op(2'b00, 64'd5, 64'd7);
        chk4("add_5_7", 64'd12, 1'b0, 1'b0, 1'b0);

        // Add overflow and wrap to zero
        op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        chk4("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk4("add_wrap", 64'd0, 1'b0, 1'b1, 1'b0);

        // Subtract
        op(2'b01, 64'h100, 64'd8);
        chk4("sub_push", 64'hF8, 1'b0, 1'b0, 1'b0);
        op(2'b01, 64'h8000_0000_0000_0000, 64'd1);
        chk4("sub_ovf_neg", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        op(2'b01, 64'd3, 64'd5);
        chk4("sub_neg", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        op(2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        chk4("sub_ovf_pos", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        op(2'b01, 64'd8, 64'd8);
        chk4("sub_eq", 64'd0, 1'b0, 1'b1, 1'b0);

        // Logic ops never flag overflow even with sign bits set
        op(2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        chk4("and", 64'hF000_F000_F000_F000, 1'b0, 1'b0, 1'b1);
        op(2'b11, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
        chk4("xor", 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0, 1'b0);
        op(2'b11, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00);
        chk4("xor_self", 64'd0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: output holds previous value until the edge
        op(2'b00, 64'd10, 64'd3);
        chk4("pipe_add", 64'd13, 1'b0, 1'b0, 1'b0);
        {c1, c0} = 2'b01;
        #2;
        check("pipe_hold", output_alu, 64'd13);
        op(2'b01, 64'd10, 64'd3);
        chk4("pipe_sub", 64'd7, 1'b0, 1'b0, 1'b0);
        op(2'b10, 64'd10, 64'd3);
        chk4("pipe_and", 64'd2, 1'b0, 1'b0, 1'b0);
        op(2'b11, 64'd10, 64'd3);
        chk4("pipe_xor", 64'd9, 1'b0, 1'b0, 1'b0);

        // Reset on the same edge as an add discards it
        op(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        check("pre_rst_ovf", {63'd0, bit_overflow}, 64'd1);
        reset_n = 1'b0;
        op(2'b00, 64'd1, 64'd1);
        chk4("mid_reset", 64'd0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b1;
        op(2'b01, 64'd4, 64'd6);
        chk4("after_reset", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        op(2'b00, 64'd8, 64'h1000);
        chk4("pop_add", 64'h1008, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
